// File: rtl/tlk2711_axi_pkg.sv
// rtl/tlk2711_axi_pkg.sv - shared responses, FSM states and address helper for the AXI memory responder
package tlk2711_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    // Byte address to word index; low unaligned bits simply fall off.
    function automatic logic [63:0] word_index(input logic [63:0] byte_addr, input int unsigned byte_shift);
        return byte_addr >> byte_shift;
    endfunction

endpackage

// File: rtl/tlk2711_sdp_ram.sv
// rtl/tlk2711_sdp_ram.sv - simple dual-port RAM, byte write enables, 1-cycle registered read-first read
module tlk2711_sdp_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4096,
    localparam int AW        = $clog2(DEPTH),
    localparam int SW        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [SW-1:0]         wstrb,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-enabled write port.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < SW; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Registered read; sampling mem before the same-edge write lands makes it read-first.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tlk2711_axi_mem_responder.sv
// rtl/tlk2711_axi_mem_responder.sv - single-ID INCR AXI4 burst slave backed by local RAM
module tlk2711_axi_mem_responder
    import tlk2711_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [1:0]              s_axi_bresp
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int RAM_AW     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_IDX = ADDR_WIDTH'(MEM_DEPTH);

    logic ready_en;

    // Address readies stay low through reset and rise on the first clock after release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ready_en <= 1'b0;
        else       ready_en <= 1'b1;
    end

    // ---------------- read channel ----------------
    r_state_t              r_state, r_state_nxt;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [8:0]            rd_left;
    logic                  rd_issue, rd_pop;
    logic                  infl_vld, infl_err, infl_last;
    logic [DATA_WIDTH-1:0] ram_q, infl_data;
    logic [1:0]            fifo_cnt, fifo_cnt_pop, occupancy;
    logic                  fifo_pop, fifo_push;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_resp [2];
    logic                  fifo_last [2];
    logic                  head_vld, head_last;

    // The beat in flight out of the RAM is presented directly when the skid is empty.
    assign infl_data    = infl_err ? '0 : ram_q;
    assign occupancy    = fifo_cnt + {1'b0, infl_vld};
    assign head_vld     = (fifo_cnt != 2'd0) || infl_vld;
    assign head_last    = (fifo_cnt != 2'd0) ? fifo_last[0] : infl_last;
    assign rd_pop       = head_vld && s_axi_rready;
    assign fifo_pop     = rd_pop && (fifo_cnt != 2'd0);
    assign fifo_push    = infl_vld && !(rd_pop && (fifo_cnt == 2'd0));
    assign fifo_cnt_pop = fifo_cnt - {1'b0, fifo_pop};

    // Read next-state and fetch decision: only fetch when the skid can absorb the beat.
    always_comb begin
        r_state_nxt   = r_state;
        s_axi_arready = 1'b0;
        rd_issue      = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = ready_en;
                if (s_axi_arvalid && ready_en) r_state_nxt = R_FETCH;
            end
            R_FETCH: begin
                rd_issue    = 1'b1;
                r_state_nxt = R_DATA;
            end
            R_DATA: begin
                rd_issue = (rd_left != 9'd0) && ((occupancy < 2'd2) || rd_pop);
                if (rd_pop && head_last) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read outputs are forced to zero whenever no beat is presented.
    always_comb begin
        s_axi_rvalid = head_vld;
        s_axi_rdata  = '0;
        s_axi_rresp  = RESP_OKAY;
        s_axi_rlast  = 1'b0;
        if (fifo_cnt != 2'd0) begin
            s_axi_rdata = fifo_data[0];
            s_axi_rresp = fifo_resp[0];
            s_axi_rlast = fifo_last[0];
        end else if (infl_vld) begin
            s_axi_rdata = infl_data;
            s_axi_rresp = infl_err ? RESP_SLVERR : RESP_OKAY;
            s_axi_rlast = infl_last;
        end
    end

    // Read state, burst counters, in-flight tag and 2-entry skid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= R_IDLE;
            rd_idx    <= '0;
            rd_left   <= '0;
            infl_vld  <= 1'b0;
            infl_err  <= 1'b0;
            infl_last <= 1'b0;
            fifo_cnt  <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_resp[i] <= RESP_OKAY;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            r_state <= r_state_nxt;
            if (s_axi_arvalid && s_axi_arready) begin
                rd_idx  <= ADDR_WIDTH'(word_index(64'(s_axi_araddr), BYTE_SHIFT));
                rd_left <= {1'b0, s_axi_arlen} + 9'd1;
            end else if (rd_issue) begin
                rd_idx  <= rd_idx + ADDR_WIDTH'(1);
                rd_left <= rd_left - 9'd1;
            end
            infl_vld <= rd_issue;
            if (rd_issue) begin
                infl_err  <= (rd_idx >= DEPTH_IDX);
                infl_last <= (rd_left == 9'd1);
            end
            if (fifo_pop) begin
                fifo_data[0] <= fifo_data[1];
                fifo_resp[0] <= fifo_resp[1];
                fifo_last[0] <= fifo_last[1];
            end
            if (fifo_push) begin
                fifo_data[fifo_cnt_pop[0]] <= infl_data;
                fifo_resp[fifo_cnt_pop[0]] <= infl_err ? RESP_SLVERR : RESP_OKAY;
                fifo_last[fifo_cnt_pop[0]] <= infl_last;
            end
            fifo_cnt <= fifo_cnt_pop + {1'b0, fifo_push};
        end
    end

    // ---------------- write channel ----------------
    w_state_t              w_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [7:0]            wr_len, wr_beat;
    logic                  wr_err, w_hs, wr_in_range, wr_final;

    assign w_hs        = s_axi_wvalid && (w_state == W_DATA);
    assign wr_in_range = (wr_idx < DEPTH_IDX);
    assign wr_final    = (wr_beat == wr_len);

    // Write next-state and handshake outputs.
    always_comb begin
        w_state_nxt   = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = RESP_OKAY;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = ready_en;
                if (s_axi_awvalid && ready_en) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && (s_axi_wlast || wr_final)) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = wr_err ? RESP_SLVERR : RESP_OKAY;
                if (s_axi_bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write state, beat counter and sticky error (range or wlast/length disagreement).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state <= W_IDLE;
            wr_idx  <= '0;
            wr_len  <= '0;
            wr_beat <= '0;
            wr_err  <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (s_axi_awvalid && s_axi_awready) begin
                wr_idx  <= ADDR_WIDTH'(word_index(64'(s_axi_awaddr), BYTE_SHIFT));
                wr_len  <= s_axi_awlen;
                wr_beat <= '0;
                wr_err  <= 1'b0;
            end else if (w_hs) begin
                wr_idx  <= wr_idx + ADDR_WIDTH'(1);
                wr_beat <= wr_beat + 8'd1;
                if (!wr_in_range || (s_axi_wlast != wr_final)) wr_err <= 1'b1;
            end
        end
    end

    tlk2711_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_hs && wr_in_range),
        .waddr (wr_idx[RAM_AW-1:0]),
        .wstrb (s_axi_wstrb),
        .wdata (s_axi_wdata),
        .re    (rd_issue && (rd_idx < DEPTH_IDX)),
        .raddr (rd_idx[RAM_AW-1:0]),
        .rdata (ram_q)
    );

endmodule
